// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage: memory op encoding,
// FSM state encoding, lane/offset constants and op classification functions.
package mem_stage_pkg;

   localparam int word_w_c = 32;
   localparam int lanes_c  = 4;
   localparam int off_w_c  = 2;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LH   = 4'd2,
      MEM_LW   = 4'd3,
      MEM_LBU  = 4'd4,
      MEM_LHU  = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   function automatic logic is_load(input mem_op_t op);
      case (op)
         MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: is_load = 1'b1;
         default:                                  is_load = 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input mem_op_t op);
      case (op)
         MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
         default:                is_store = 1'b0;
      endcase
   endfunction

   // Halfwords must sit on an even byte, words on a word boundary.
   function automatic logic is_misaligned(input mem_op_t op, input logic [off_w_c-1:0] off);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: is_misaligned = off[0];
         MEM_LW, MEM_SW:          is_misaligned = (off != 2'b00);
         default:                 is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage: req/gnt request channel plus
// rvalid/rdata response channel. The stage is the master.
interface mem_stage_if #(
   parameter int wd_regs_p = 32
) ();

   logic                 req;
   logic                 gnt;
   logic [wd_regs_p-1:0] addr;
   logic                 we;
   logic [3:0]           be;
   logic [wd_regs_p-1:0] wdata;
   logic                 rvalid;
   logic [wd_regs_p-1:0] rdata;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/mem_stage_align.sv
// mem_align: combinational byte-lane steering for the memory stage.
// Store side: byte enables and lane-replicated write data from op/offset.
// Load side: byte/half extraction from the returned word with sign or
// zero extension. Misaligned offsets are truncated to the natural alignment.
module mem_align
   import mem_stage_pkg::*;
(
   input  mem_op_t               op_i,
   input  logic [off_w_c-1:0]    off_i,
   input  logic [word_w_c-1:0]   store_data_i,
   input  logic [word_w_c-1:0]   rdata_i,
   output logic [lanes_c-1:0]    be_o,
   output logic [word_w_c-1:0]   wdata_o,
   output logic [word_w_c-1:0]   ld_data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign byte_s = rdata_i[{off_i, 3'b000} +: 8];
   assign half_s = rdata_i[{off_i[1], 4'b0000} +: 16];

   // Byte enables and replicated store data for the addressed lanes
   always_comb begin
      be_o    = 4'b0000;
      wdata_o = store_data_i;
      case (op_i)
         MEM_SB: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{store_data_i[7:0]}};
         end
         MEM_SH: begin
            be_o    = 4'b0011 << {off_i[1], 1'b0};
            wdata_o = {2{store_data_i[15:0]}};
         end
         MEM_SW, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: begin
            be_o    = 4'b1111;
            wdata_o = store_data_i;
         end
         default: begin
            be_o    = 4'b0000;
            wdata_o = store_data_i;
         end
      endcase
   end

   // Load value extraction and extension
   always_comb begin
      ld_data_o = rdata_i;
      case (op_i)
         MEM_LB:  ld_data_o = {{24{byte_s[7]}}, byte_s};
         MEM_LBU: ld_data_o = {24'h000000, byte_s};
         MEM_LH:  ld_data_o = {{16{half_s[15]}}, half_s};
         MEM_LHU: ld_data_o = {16'h0000, half_s};
         default: ld_data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage behind execute. Accepts one instruction at
// a time, issues at most one data-memory transaction, and emits a registered
// one-cycle writeback pulse per accepted instruction.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned memory ops issue no request
// and instead produce a writeback pulse with o_misaligned set.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int wd_regs_p  = 32,
   parameter int wd_rdest_p = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [wd_regs_p-1:0]  i_result,
   input  logic [wd_regs_p-1:0]  i_store_data,
   input  mem_op_t               i_mem_op,
   input  logic [wd_rdest_p-1:0] i_rdest,
   input  logic                  i_rd_we,
   mem_stage_if.master           dmem,
   output logic                  o_wb_valid,
   output logic                  o_wb_we,
   output logic [wd_rdest_p-1:0] o_wb_rdest,
   output logic [wd_regs_p-1:0]  o_wb_data
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic                  o_misaligned
`endif
);

   if (wd_regs_p != 32) begin : g_width_chk
      $error("mem_stage: only a 32-bit datapath is supported");
   end

   state_t                 state_q, state_d;
   logic                   ready_q;
   logic                   req_q;
   logic [wd_regs_p-1:0]   addr_q;
   logic                   we_q;
   logic [lanes_c-1:0]     be_q;
   logic [wd_regs_p-1:0]   wdata_q;
   mem_op_t                op_q;
   logic [off_w_c-1:0]     off_q;
   logic [wd_rdest_p-1:0]  rdest_q;
   logic                   rd_we_q;
   logic                   wb_valid_q;
   logic                   wb_we_q;
   logic [wd_rdest_p-1:0]  wb_rdest_q;
   logic [wd_regs_p-1:0]   wb_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
   logic                   misaligned_q;
`endif

   logic                   accept_s;
   logic                   trap_s;
   mem_op_t                align_op_s;
   logic [off_w_c-1:0]     align_off_s;
   logic [lanes_c-1:0]     align_be_s;
   logic [wd_regs_p-1:0]   align_wdata_s;
   logic [wd_regs_p-1:0]   align_ld_s;

   // ready_q is only ever high in IDLE, so it alone qualifies a transfer
   assign accept_s = i_valid & ready_q;

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap_s = is_misaligned(i_mem_op, i_result[1:0]);
`else
   assign trap_s = 1'b0;
`endif

   // In IDLE the aligner sees the incoming op (store lanes); afterwards it
   // sees the captured op so the load path can extract the returned word.
   assign align_op_s  = (state_q == ST_IDLE) ? i_mem_op      : op_q;
   assign align_off_s = (state_q == ST_IDLE) ? i_result[1:0] : off_q;

   mem_align u_align (
      .op_i         (align_op_s),
      .off_i        (align_off_s),
      .store_data_i (i_store_data),
      .rdata_i      (dmem.rdata),
      .be_o         (align_be_s),
      .wdata_o      (align_wdata_s),
      .ld_data_o    (align_ld_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && (i_mem_op != MEM_NONE) && !trap_s) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (dmem.gnt) begin
               state_d = is_load(op_q) ? ST_WAIT : ST_IDLE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (dmem.rvalid) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture, memory request and writeback registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q      <= 1'b0;
         req_q        <= 1'b0;
         addr_q       <= {wd_regs_p{1'b0}};
         we_q         <= 1'b0;
         be_q         <= 4'b0000;
         wdata_q      <= {wd_regs_p{1'b0}};
         op_q         <= MEM_NONE;
         off_q        <= 2'b00;
         rdest_q      <= {wd_rdest_p{1'b0}};
         rd_we_q      <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_we_q      <= 1'b0;
         wb_rdest_q   <= {wd_rdest_p{1'b0}};
         wb_data_q    <= {wd_regs_p{1'b0}};
`ifdef MEM_MISALIGN_TRAP_EN
         misaligned_q <= 1'b0;
`endif
      end else begin
         ready_q    <= (state_d == ST_IDLE);
         wb_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         misaligned_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  if (i_mem_op == MEM_NONE) begin
                     wb_valid_q <= 1'b1;
                     wb_we_q    <= i_rd_we;
                     wb_rdest_q <= i_rdest;
                     wb_data_q  <= i_result;
                  end else if (trap_s) begin
                     wb_valid_q <= 1'b1;
                     wb_we_q    <= 1'b0;
                     wb_rdest_q <= i_rdest;
                     wb_data_q  <= {wd_regs_p{1'b0}};
`ifdef MEM_MISALIGN_TRAP_EN
                     misaligned_q <= 1'b1;
`endif
                  end else begin
                     req_q   <= 1'b1;
                     addr_q  <= {i_result[wd_regs_p-1:2], 2'b00};
                     we_q    <= is_store(i_mem_op);
                     be_q    <= align_be_s;
                     wdata_q <= align_wdata_s;
                     op_q    <= i_mem_op;
                     off_q   <= i_result[1:0];
                     rdest_q <= i_rdest;
                     rd_we_q <= i_rd_we;
                  end
               end
            end
            ST_REQ: begin
               if (dmem.gnt) begin
                  req_q <= 1'b0;
                  if (is_store(op_q)) begin
                     wb_valid_q <= 1'b1;
                     wb_we_q    <= 1'b0;
                     wb_rdest_q <= rdest_q;
                     wb_data_q  <= {wd_regs_p{1'b0}};
                  end
               end
            end
            ST_WAIT: begin
               if (dmem.rvalid) begin
                  wb_valid_q <= 1'b1;
                  wb_we_q    <= rd_we_q;
                  wb_rdest_q <= rdest_q;
                  wb_data_q  <= align_ld_s;
               end
            end
            default: begin
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready     = ready_q;
   assign dmem.req    = req_q;
   assign dmem.addr   = addr_q;
   assign dmem.we     = we_q;
   assign dmem.be     = be_q;
   assign dmem.wdata  = wdata_q;
   assign o_wb_valid  = wb_valid_q;
   assign o_wb_we     = wb_we_q;
   assign o_wb_rdest  = wb_rdest_q;
   assign o_wb_data   = wb_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
   assign o_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with a transaction-level reference model:
// expected requests and writeback results are computed from address/op
// arithmetic and queued, and a negedge compare process checks every cycle.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_result = 32'd0;
   logic [31:0] i_store_data = 32'd0;
   mem_op_t     i_mem_op = MEM_NONE;
   logic [4:0]  i_rdest = 5'd0;
   logic        i_rd_we = 1'b0;
   logic        o_wb_valid;
   logic        o_wb_we;
   logic [4:0]  o_wb_rdest;
   logic [31:0] o_wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        o_misaligned;
`endif

   mem_stage_if #(.wd_regs_p(32)) dmem_if ();

   mem_stage #(.wd_regs_p(32), .wd_rdest_p(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_result     (i_result),
      .i_store_data (i_store_data),
      .i_mem_op     (i_mem_op),
      .i_rdest      (i_rdest),
      .i_rd_we      (i_rd_we),
      .dmem         (dmem_if),
      .o_wb_valid   (o_wb_valid),
      .o_wb_we      (o_wb_we),
      .o_wb_rdest   (o_wb_rdest),
      .o_wb_data    (o_wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .o_misaligned (o_misaligned)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        chk_data;
      logic        mis;
   } wb_t;

   wb_t         exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          chk_en = 1'b0;
   bit          exp_req_active = 1'b0;
   bit          exp_wait = 1'b0;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_be;
   logic        exp_we;
   mem_op_t     cur_op;
   logic [31:0] cur_addr;
   logic [4:0]  cur_rd;
   logic        cur_we;
   bit          exp_pulse;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---- reference model ----
   function automatic bit m_store(input mem_op_t op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   function automatic bit m_mis(input mem_op_t op, input logic [31:0] a);
      if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return (a % 2) != 0;
      if (op == MEM_LW || op == MEM_SW) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_be(input mem_op_t op, input logic [31:0] a);
      int off;
      off = int'(a % 4);
      case (op)
         MEM_SB:   return 4'(1 << off);
         MEM_SH:   return (off >= 2) ? 4'b1100 : 4'b0011;
         MEM_NONE: return 4'b0000;
         default:  return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input mem_op_t op, input logic [31:0] sd);
      case (op)
         MEM_SB:  return 32'(sd[7:0]) * 32'h0101_0101;
         MEM_SH:  return 32'(sd[15:0]) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input mem_op_t op, input logic [31:0] a, input logic [31:0] rd);
      longint b, h;
      int off;
      off = int'(a % 4);
      b = longint'((rd >> (8 * off)) & 32'h0000_00FF);
      h = longint'((rd >> (16 * (off / 2))) & 32'h0000_FFFF);
      case (op)
         MEM_LB:  return (b >= 128)   ? 32'(b - 256)   : 32'(b);
         MEM_LBU: return 32'(b);
         MEM_LH:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
         MEM_LHU: return 32'(h);
         default: return rd;
      endcase
   endfunction

   function automatic bit m_trap(input mem_op_t op, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
      return m_mis(op, a);
`else
      return (op == MEM_NONE) && (a != a);
`endif
   endfunction

   task automatic push_wb(input logic we, input logic [4:0] rd, input logic [31:0] d,
                          input logic cd, input logic mis);
      wb_t e;
      e.due = cyc; e.we = we; e.rd = rd; e.data = d; e.chk_data = cd; e.mis = mis;
      exp_q.push_back(e);
   endtask

   // ---- per-cycle compare against the model ----
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", 32'(o_ready), 32'(!(exp_req_active || exp_wait)));
         chk("req", 32'(dmem_if.req), 32'(exp_req_active));
         if (exp_req_active) begin
            chk("addr",  dmem_if.addr, exp_addr);
            chk("we",    32'(dmem_if.we), 32'(exp_we));
            chk("be",    32'(dmem_if.be), 32'(exp_be));
            chk("wdata", dmem_if.wdata, exp_wdata);
         end
         exp_pulse = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         chk("wb_valid", 32'(o_wb_valid), 32'(exp_pulse));
         if (exp_pulse) begin
            chk("wb_we", 32'(o_wb_we), 32'(exp_q[0].we));
            if (exp_q[0].we) chk("wb_rdest", 32'(o_wb_rdest), 32'(exp_q[0].rd));
            if (exp_q[0].chk_data) chk("wb_data", o_wb_data, exp_q[0].data);
`ifdef MEM_MISALIGN_TRAP_EN
            chk("misaligned", 32'(o_misaligned), 32'(exp_q[0].mis));
`endif
            void'(exp_q.pop_front());
         end else begin
`ifdef MEM_MISALIGN_TRAP_EN
            chk("misaligned_idle", 32'(o_misaligned), 32'd0);
`endif
         end
      end
   end

   // ---- stimulus primitives (called at posedge+1) ----
   task automatic accept(input mem_op_t op, input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we);
      int n;
      n = 0;
      while (!o_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         chk("accept_timeout", 32'd1, 32'd0);
      end else begin
         i_valid = 1'b1; i_mem_op = op; i_result = res; i_store_data = sd;
         i_rdest = rd; i_rd_we = we;
         @(posedge clk); #1;
         i_valid = 1'b0;
         if (op == MEM_NONE) begin
            push_wb(we, rd, res, 1'b1, 1'b0);
         end else if (m_trap(op, res)) begin
            push_wb(1'b0, rd, 32'd0, 1'b0, 1'b1);
         end else begin
            exp_req_active = 1'b1;
            exp_addr  = res & 32'hFFFF_FFFC;
            exp_we    = m_store(op);
            exp_be    = m_be(op, res);
            exp_wdata = m_store(op) ? m_wdata(op, sd) : dmem_if.wdata;
            cur_op = op; cur_addr = res; cur_rd = rd; cur_we = we;
         end
      end
   endtask

   task automatic grant(input int g);
      repeat (g) begin @(posedge clk); #1; end
      dmem_if.gnt = 1'b1;
      @(posedge clk); #1;
      dmem_if.gnt = 1'b0;
      exp_req_active = 1'b0;
      if (m_store(cur_op)) push_wb(1'b0, cur_rd, 32'd0, 1'b0, 1'b0);
      else exp_wait = 1'b1;
   endtask

   task automatic respond(input int r, input logic [31:0] d);
      repeat (r) begin @(posedge clk); #1; end
      dmem_if.rvalid = 1'b1; dmem_if.rdata = d;
      @(posedge clk); #1;
      dmem_if.rvalid = 1'b0;
      exp_wait = 1'b0;
      push_wb(cur_we, cur_rd, m_load(cur_op, cur_addr, d), 1'b1, 1'b0);
   endtask

   task automatic stray_rvalid(input logic [31:0] d);
      dmem_if.rvalid = 1'b1; dmem_if.rdata = d;
      @(posedge clk); #1;
      dmem_if.rvalid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset_pulse();
      chk_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_req",   32'(dmem_if.req), 32'd0);
      chk("rst_wbv",   32'(o_wb_valid), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      exp_q.delete(); exp_req_active = 1'b0; exp_wait = 1'b0;
      dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready_after", 32'(o_ready), 32'd1);
      chk_en = 1'b1;
   endtask

   initial begin
      dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = 32'd0;

      // model pins (hand-computed)
      chk("pin_lb",  m_load(MEM_LB,  32'h102, 32'h0080_0000), 32'hFFFF_FF80);
      chk("pin_lbu", m_load(MEM_LBU, 32'h102, 32'h0080_0000), 32'h0000_0080);
      chk("pin_lh",  m_load(MEM_LH,  32'h102, 32'h8001_0000), 32'hFFFF_8001);
      chk("pin_be",  32'(m_be(MEM_SB, 32'h103)), 32'h8);
      chk("pin_wd",  m_wdata(MEM_SB, 32'h0000_00AB), 32'hABAB_ABAB);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 32'(o_ready), 32'd0);
      chk("reset_req",   32'(dmem_if.req), 32'd0);
      chk("reset_wbv",   32'(o_wb_valid), 32'd0);
      chk("reset_wbd",   o_wb_data, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_first_clk", 32'(o_ready), 32'd1);
      chk_en = 1'b1;

      // 1: MEM_NONE back to back
      i_valid = 1'b1; i_mem_op = MEM_NONE; i_result = 32'h1234_5678;
      i_rdest = 5'd7; i_rd_we = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         push_wb(1'b1, 5'd7, 32'h1234_5678, 1'b1, 1'b0);
         chk("t1_data", o_wb_data, 32'h1234_5678);
      end
      i_valid = 1'b0;
      @(posedge clk); #1;

      // 2: SB with delayed grant
      accept(MEM_SB, 32'h103, 32'h0000_00AB, 5'd3, 1'b0);
      chk("t2_addr",  dmem_if.addr, 32'h0000_0100);
      chk("t2_be",    32'(dmem_if.be), 32'h8);
      chk("t2_wdata", dmem_if.wdata, 32'hABAB_ABAB);
      grant(2);

      // 3: sub-word loads and stores
      accept(MEM_LB, 32'h102, 32'd0, 5'd4, 1'b1);  grant(1); respond(0, 32'h0080_0000);
      chk("t3_lb", o_wb_data, 32'hFFFF_FF80);
      accept(MEM_LBU, 32'h102, 32'd0, 5'd5, 1'b1); grant(0); respond(1, 32'h0080_0000);
      accept(MEM_LH, 32'h102, 32'd0, 5'd6, 1'b1);  grant(0); respond(0, 32'h8001_0000);
      accept(MEM_LHU, 32'h100, 32'd0, 5'd8, 1'b1); grant(0); respond(0, 32'h1234_9ABC);
      accept(MEM_LB, 32'h101, 32'd0, 5'd9, 1'b1);  grant(0); respond(0, 32'h0000_7F00);
      accept(MEM_SH, 32'h202, 32'hCAFE_1234, 5'd1, 1'b0); grant(1);
      accept(MEM_SW, 32'h204, 32'h0BAD_F00D, 5'd1, 1'b0); grant(0);

      // 4: LW with immediate grant, then stray rvalid in IDLE
      accept(MEM_LW, 32'h300, 32'd0, 5'd9, 1'b1); grant(0); respond(1, 32'hDEAD_BEEF);
      chk("t4_data", o_wb_data, 32'hDEAD_BEEF);
      chk("t4_rd",   32'(o_wb_rdest), 32'd9);
      stray_rvalid(32'h5555_5555);

      // 5: reset in WAIT, reset in REQ, then normal operation
      accept(MEM_LW, 32'h400, 32'd0, 5'd10, 1'b1); grant(0);
      do_reset_pulse();
      stray_rvalid(32'h6666_6666);
      accept(MEM_SW, 32'h500, 32'h1111_2222, 5'd2, 1'b0);
      do_reset_pulse();
      accept(MEM_LH, 32'h406, 32'd0, 5'd11, 1'b1); grant(1); respond(0, 32'h7FFE_0000);
      chk("t5_data", o_wb_data, 32'h0000_7FFE);

      // 6: misaligned word load / halfword store
`ifdef MEM_MISALIGN_TRAP_EN
      accept(MEM_LW, 32'h101, 32'd0, 5'd12, 1'b1);
      chk("t6_noreq", 32'(dmem_if.req), 32'd0);
      chk("t6_mis",   32'(o_misaligned), 32'd1);
      chk("t6_wbwe",  32'(o_wb_we), 32'd0);
      accept(MEM_SH, 32'h103, 32'h0000_BEEF, 5'd0, 1'b0);
`else
      accept(MEM_LW, 32'h101, 32'd0, 5'd12, 1'b1);
      chk("t6_addr", dmem_if.addr, 32'h0000_0100);
      chk("t6_be",   32'(dmem_if.be), 32'hF);
      grant(0); respond(0, 32'hA5A5_0F0F);
      accept(MEM_SH, 32'h103, 32'h0000_BEEF, 5'd0, 1'b0);
      grant(0);
`endif

      repeat (4) begin @(posedge clk); #1; end
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
